memory_stage: RTL and testbench

Memory pipeline stage of the RV32 pipelined core: the M pipeline register fed by execute, plus a load/store unit that drives the data-memory request/grant/response bus. It formats store data and byte enables, aligns and extends load data, and hands the full bundle (including `reduced_data`) to the writeback stage. It raises a stall request to the hazard unit while an access is outstanding, and emits a bubble downstream during that time.

---
 rtl/memory_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_memory_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage of the RV32 pipeline: M pipeline register, load/store unit
// driving the data-memory req/gnt/rvalid bus, and load/store formatting.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no access in flight; request issued while M holds a mem op
// WAIT_RESP | load granted, waiting for rvalid
// HOLD      | access finished, stage stalled externally; no reissue
// DRAIN     | load was flushed after grant; swallow its late response
module memory_stage (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] instr_e_i,
  input  logic [31:0] alu_result_e_i,
  input  logic [31:0] write_data_e_i,
  input  logic [31:0] pc_target_e_i,
  input  logic [31:0] pc_plus4_e_i,
  input  logic [31:0] imm_ext_e_i,
  input  logic [31:0] csr_result_e_i,
  input  logic [31:0] csr_data_e_i,
  input  logic [11:0] csr_addr_e_i,
  input  logic [4:0]  rd_e_i,
  input  logic [2:0]  result_src_e_i,
  input  logic [2:0]  funct3_e_i,
  input  logic        valid_e_i,
  input  logic        reg_write_e_i,
  input  logic        csr_we_e_i,
  input  logic        mem_read_e_i,
  input  logic        mem_write_e_i,
  input  logic        stall_m_i,
  input  logic        flush_m_i,
  output logic [31:0] instr_m_o,
  output logic [31:0] alu_result_m_o,
  output logic [31:0] reduced_data_m_o,
  output logic [31:0] pc_target_m_o,
  output logic [31:0] pc_plus4_m_o,
  output logic [31:0] imm_ext_m_o,
  output logic [31:0] csr_result_m_o,
  output logic [31:0] csr_data_m_o,
  output logic [11:0] csr_addr_m_o,
  output logic [4:0]  rd_m_o,
  output logic [2:0]  result_src_m_o,
  output logic        valid_m_o,
  output logic        reg_write_m_o,
  output logic        csr_we_m_o,
  output logic        mem_busy_o,
  output logic        misaligned_m_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_RESP, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] load_buf;
  logic [31:0] write_data_q;
  logic [2:0]  funct3_q;
  logic        valid_q;
  logic        reg_write_q;
  logic        csr_we_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic [1:0]  byte_off;
  logic        is_half;
  logic        is_word;
  logic        mem_access;
  logic        op;
  logic [3:0]  be_mask;
  logic [31:0] wdata_fmt;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // M pipeline register; flush wins over stall and only kills the controls
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      instr_m_o      <= '0;
      alu_result_m_o <= '0;
      write_data_q   <= '0;
      pc_target_m_o  <= '0;
      pc_plus4_m_o   <= '0;
      imm_ext_m_o    <= '0;
      csr_result_m_o <= '0;
      csr_data_m_o   <= '0;
      csr_addr_m_o   <= '0;
      rd_m_o         <= '0;
      result_src_m_o <= '0;
      funct3_q       <= '0;
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      csr_we_q       <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
    end else if (flush_m_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      csr_we_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!stall_m_i) begin
      instr_m_o      <= instr_e_i;
      alu_result_m_o <= alu_result_e_i;
      write_data_q   <= write_data_e_i;
      pc_target_m_o  <= pc_target_e_i;
      pc_plus4_m_o   <= pc_plus4_e_i;
      imm_ext_m_o    <= imm_ext_e_i;
      csr_result_m_o <= csr_result_e_i;
      csr_data_m_o   <= csr_data_e_i;
      csr_addr_m_o   <= csr_addr_e_i;
      rd_m_o         <= rd_e_i;
      result_src_m_o <= result_src_e_i;
      funct3_q       <= funct3_e_i;
      valid_q        <= valid_e_i;
      reg_write_q    <= reg_write_e_i;
      csr_we_q       <= csr_we_e_i;
      mem_read_q     <= mem_read_e_i;
      mem_write_q    <= mem_write_e_i;
    end
  end

  // access decode, alignment check and store formatting
  always_comb begin
    byte_off       = alu_result_m_o[1:0];
    is_half        = (funct3_q[1:0] == 2'b01);
    is_word        = (funct3_q[1:0] == 2'b10);
    mem_access     = valid_q & (mem_read_q | mem_write_q);
    misaligned_m_o = mem_access & ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));
    op             = mem_access & ~misaligned_m_o;
    be_mask        = 4'b1111;
    wdata_fmt      = write_data_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_mask   = 4'b0001 << byte_off;
        wdata_fmt = {4{write_data_q[7:0]}};
      end
      2'b01: begin
        be_mask   = 4'b0011 << byte_off;
        wdata_fmt = {2{write_data_q[15:0]}};
      end
      default: ;
    endcase
  end

  // request side is combinational so it stays stable until grant
  always_comb begin
    dmem_req_o   = (state == IDLE) & op;
    dmem_we_o    = dmem_req_o & mem_write_q;
    dmem_addr_o  = {alu_result_m_o[31:2], 2'b00};
    dmem_be_o    = op ? be_mask : 4'b0000;
    dmem_wdata_o = wdata_fmt;
  end

  // load alignment/extension, bypassing the buffer in the response cycle
  always_comb begin
    load_word = (state == WAIT_RESP && dmem_rvalid_i) ? dmem_rdata_i : load_buf;
    case (byte_off)
      2'b00:   load_byte = load_word[7:0];
      2'b01:   load_byte = load_word[15:8];
      2'b10:   load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = byte_off[1] ? load_word[31:16] : load_word[15:0];
    case (funct3_q)
      3'b000:  reduced_data_m_o = {{24{load_byte[7]}}, load_byte};
      3'b001:  reduced_data_m_o = {{16{load_half[15]}}, load_half};
      3'b100:  reduced_data_m_o = {24'b0, load_byte};
      3'b101:  reduced_data_m_o = {16'b0, load_half};
      default: reduced_data_m_o = load_word;
    endcase
  end

  // busy never looks at stall_m_i, keeping the hazard loop open
  always_comb begin
    mem_busy_o = ((state == IDLE) & op & ~(dmem_gnt_i & mem_write_q))
               | ((state == WAIT_RESP) & ~dmem_rvalid_i)
               | (state == DRAIN);
    valid_m_o     = valid_q & ~mem_busy_o;
    reg_write_m_o = reg_write_q & ~mem_busy_o & ~misaligned_m_o;
    csr_we_m_o    = csr_we_q & ~mem_busy_o;
  end

  // access sequencer and load buffer
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      load_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op && dmem_gnt_i) begin
            if (mem_write_q) state <= (stall_m_i && !flush_m_i) ? HOLD : IDLE;
            else             state <= flush_m_i ? DRAIN : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (dmem_rvalid_i) begin
            load_buf <= dmem_rdata_i;
            state    <= (stall_m_i && !flush_m_i) ? HOLD : IDLE;
          end else if (flush_m_i) begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (!stall_m_i || flush_m_i) state <= IDLE;
        end
        DRAIN: begin
          if (dmem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed plus randomized checks of memory_stage against an arithmetic
// model of the load/store formatting rules and the zero/N-wait handshake.
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [31:0] instr_e_i, alu_result_e_i, write_data_e_i, pc_target_e_i;
  logic [31:0] pc_plus4_e_i, imm_ext_e_i, csr_result_e_i, csr_data_e_i;
  logic [11:0] csr_addr_e_i;
  logic [4:0]  rd_e_i;
  logic [2:0]  result_src_e_i, funct3_e_i;
  logic        valid_e_i, reg_write_e_i, csr_we_e_i, mem_read_e_i, mem_write_e_i;
  logic        stall_m_i, flush_m_i;
  logic [31:0] instr_m_o, alu_result_m_o, reduced_data_m_o, pc_target_m_o;
  logic [31:0] pc_plus4_m_o, imm_ext_m_o, csr_result_m_o, csr_data_m_o;
  logic [11:0] csr_addr_m_o;
  logic [4:0]  rd_m_o;
  logic [2:0]  result_src_m_o;
  logic        valid_m_o, reg_write_m_o, csr_we_m_o, mem_busy_o, misaligned_m_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int checks = 0;
  int errors = 0;
  logic [4:0] rd_exp;

  always #5 clk_i = ~clk_i;

  memory_stage dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .instr_e_i(instr_e_i), .alu_result_e_i(alu_result_e_i),
    .write_data_e_i(write_data_e_i), .pc_target_e_i(pc_target_e_i),
    .pc_plus4_e_i(pc_plus4_e_i), .imm_ext_e_i(imm_ext_e_i),
    .csr_result_e_i(csr_result_e_i), .csr_data_e_i(csr_data_e_i),
    .csr_addr_e_i(csr_addr_e_i), .rd_e_i(rd_e_i),
    .result_src_e_i(result_src_e_i), .funct3_e_i(funct3_e_i),
    .valid_e_i(valid_e_i), .reg_write_e_i(reg_write_e_i),
    .csr_we_e_i(csr_we_e_i), .mem_read_e_i(mem_read_e_i),
    .mem_write_e_i(mem_write_e_i), .stall_m_i(stall_m_i), .flush_m_i(flush_m_i),
    .instr_m_o(instr_m_o), .alu_result_m_o(alu_result_m_o),
    .reduced_data_m_o(reduced_data_m_o), .pc_target_m_o(pc_target_m_o),
    .pc_plus4_m_o(pc_plus4_m_o), .imm_ext_m_o(imm_ext_m_o),
    .csr_result_m_o(csr_result_m_o), .csr_data_m_o(csr_data_m_o),
    .csr_addr_m_o(csr_addr_m_o), .rd_m_o(rd_m_o),
    .result_src_m_o(result_src_m_o), .valid_m_o(valid_m_o),
    .reg_write_m_o(reg_write_m_o), .csr_we_m_o(csr_we_m_o),
    .mem_busy_o(mem_busy_o), .misaligned_m_o(misaligned_m_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // reference model: access size in bytes from funct3
  function automatic int unsigned size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz, m;
    sz = size_of(f3);
    if (sz == 4) return 4'hF;
    m = ((1 << sz) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int unsigned sz;
    sz = size_of(f3);
    if (sz == 1) return (d % 256) * 32'h0101_0101;
    if (sz == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned sz;
    logic [31:0] v;
    sz = size_of(f3);
    if (sz == 4) return rdata;
    v = (rdata >> (8 * (addr % 4))) % (32'd1 << (8 * sz));
    if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  task automatic set_ex(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
    instr_e_i = $urandom; alu_result_e_i = addr; write_data_e_i = data;
    pc_target_e_i = $urandom; pc_plus4_e_i = $urandom; imm_ext_e_i = $urandom;
    csr_result_e_i = $urandom; csr_data_e_i = $urandom;
    csr_addr_e_i = 12'($urandom); rd_e_i = 5'($urandom_range(1, 31));
    result_src_e_i = 3'd1; funct3_e_i = f3;
    valid_e_i = 1'b1; reg_write_e_i = mr; csr_we_e_i = 1'b0;
    mem_read_e_i = mr; mem_write_e_i = mw;
    rd_exp = rd_e_i;
  endtask

  task automatic bubble_ex();
    valid_e_i = 1'b0; reg_write_e_i = 1'b0; csr_we_e_i = 1'b0;
    mem_read_e_i = 1'b0; mem_write_e_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // one memory instruction through M, with gnt/rvalid delays and an optional
  // external stall after completion
  task automatic do_op(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input int gnt_dly,
                       input int rv_dly, input logic hold);
    logic [31:0] ld;
    set_ex(mr, mw, f3, addr, data);
    stall_m_i = 1'b0; flush_m_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    tick();
    bubble_ex();
    if (exp_mis(f3, addr)) begin
      #3;
      checkb("mis_flag", misaligned_m_o, 1'b1);
      checkb("mis_req", dmem_req_o, 1'b0);
      checkb("mis_regwr", reg_write_m_o, 1'b0);
      checkb("mis_busy", mem_busy_o, 1'b0);
      tick();
      return;
    end
    for (int k = 0; k < gnt_dly; k++) begin
      dmem_gnt_i = 1'b0; stall_m_i = 1'b1;
      #3;
      checkb("wait_gnt_req", dmem_req_o, 1'b1);
      check("wait_gnt_addr", dmem_addr_o, {addr[31:2], 2'b00});
      check("wait_gnt_be", {28'b0, dmem_be_o}, {28'b0, exp_be(f3, addr)});
      checkb("wait_gnt_busy", mem_busy_o, 1'b1);
      checkb("wait_gnt_valid", valid_m_o, 1'b0);
      if (mw) check("wait_gnt_wdata", dmem_wdata_o, exp_wdata(f3, data));
      tick();
    end
    dmem_gnt_i = 1'b1;
    stall_m_i = mr ? 1'b1 : hold;
    #3;
    checkb("gnt_req", dmem_req_o, 1'b1);
    checkb("gnt_we", dmem_we_o, mw);
    check("gnt_addr", dmem_addr_o, {addr[31:2], 2'b00});
    check("gnt_be", {28'b0, dmem_be_o}, {28'b0, exp_be(f3, addr)});
    checkb("gnt_busy", mem_busy_o, mr);
    if (mw) begin
      check("st_wdata", dmem_wdata_o, exp_wdata(f3, data));
      checkb("st_valid", valid_m_o, 1'b1);
    end
    tick();
    dmem_gnt_i = 1'b0;
    if (mw) begin
      if (hold) begin
        #3;
        checkb("st_hold_req", dmem_req_o, 1'b0);
        checkb("st_hold_busy", mem_busy_o, 1'b0);
        stall_m_i = 1'b0;
        tick();
      end
      return;
    end
    for (int k = 0; k < rv_dly; k++) begin
      stall_m_i = 1'b1;
      #3;
      checkb("wait_rv_req", dmem_req_o, 1'b0);
      checkb("wait_rv_busy", mem_busy_o, 1'b1);
      tick();
    end
    ld = exp_load(f3, addr, rdata);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; stall_m_i = hold;
    #3;
    checkb("ld_busy", mem_busy_o, 1'b0);
    checkb("ld_valid", valid_m_o, 1'b1);
    checkb("ld_regwr", reg_write_m_o, 1'b1);
    check("ld_data", reduced_data_m_o, ld);
    check("ld_rd", {27'b0, rd_m_o}, {27'b0, rd_exp});
    tick();
    dmem_rvalid_i = 1'b0;
    if (hold) begin
      for (int k = 0; k < 2; k++) begin
        dmem_rdata_i = $urandom; stall_m_i = 1'b1;
        #3;
        checkb("hold_req", dmem_req_o, 1'b0);
        checkb("hold_busy", mem_busy_o, 1'b0);
        check("hold_data", reduced_data_m_o, ld);
        tick();
      end
      stall_m_i = 1'b0;
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkb(tag, |{instr_m_o, alu_result_m_o, reduced_data_m_o, pc_target_m_o,
                  pc_plus4_m_o, imm_ext_m_o, csr_result_m_o, csr_data_m_o,
                  csr_addr_m_o, rd_m_o, result_src_m_o, valid_m_o, reg_write_m_o,
                  csr_we_m_o, mem_busy_o, misaligned_m_o, dmem_req_o, dmem_we_o,
                  dmem_addr_o, dmem_be_o, dmem_wdata_o}, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        mr;
    logic [2:0]  f3;
    logic [31:0] a;

    reset_ni = 1'b0;
    set_ex(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bubble_ex();
    stall_m_i = 1'b0; flush_m_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    #12;
    check_all_zero("reset_outputs");
    reset_ni = 1'b1;
    tick();

    // directed cases
    do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_0011, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0011, 0, 0, 1'b0);
    do_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 3, 0, 1'b1);
    do_op(1'b0, 1'b1, 3'b000, 32'h401, 32'h0000_00A5, 32'h0, 1, 0, 1'b1);

    // flush while a load waits for its response
    set_ex(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    tick();
    bubble_ex();
    dmem_gnt_i = 1'b1; stall_m_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0; flush_m_i = 1'b1;
    #3;
    checkb("flush_wait_busy", mem_busy_o, 1'b1);
    tick();
    flush_m_i = 1'b0;
    #3;
    checkb("drain_busy", mem_busy_o, 1'b1);
    checkb("drain_valid", valid_m_o, 1'b0);
    checkb("drain_req", dmem_req_o, 1'b0);
    tick();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1357_9BDF;
    #3;
    checkb("drain_rvalid_busy", mem_busy_o, 1'b1);
    tick();
    dmem_rvalid_i = 1'b0; stall_m_i = 1'b0;
    #3;
    checkb("after_drain_busy", mem_busy_o, 1'b0);
    tick();
    do_op(1'b1, 1'b0, 3'b101, 32'h602, 32'h0, 32'h8001_7FFE, 0, 0, 1'b0);

    // reset in the middle of an outstanding load
    set_ex(1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    tick();
    bubble_ex();
    dmem_gnt_i = 1'b1; stall_m_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    reset_ni = 1'b0;
    #1;
    check_all_zero("reset_mid_access");
    #3;
    stall_m_i = 1'b0;
    reset_ni = 1'b1;
    tick();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      mr = 1'($urandom_range(0, 1));
      if (mr) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      a = $urandom;
      do_op(mr, ~mr, f3, a, $urandom, $urandom, int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
